// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: step strobe, clear, weights and
// threshold in; spike pulses and spike counters out.
interface lif_neuron_array_if #(
    parameter int NUM_NEURONS  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int CNT_WIDTH    = 8
);
    logic                                clken;
    logic                                clr;
    logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] data_in;
    logic signed [POT_WIDTH-1:0]         threshold;
    logic [NUM_NEURONS-1:0]              spike_out;
    logic [NUM_NEURONS*CNT_WIDTH-1:0]    spike_cnt;

    modport master (
        output clken, clr, data_in, threshold,
        input  spike_out, spike_cnt
    );

    modport slave (
        input  clken, clr, data_in, threshold,
        output spike_out, spike_cnt
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons with saturating potentials,
// refractory window and saturating spike counters. Leak is enabled by
// defining LIF_LEAK_EN (v -= v >>> LEAK_SHIFT on each integrating step).
module lif_neuron_array #(
    parameter int NUM_NEURONS  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int REFRACTORY   = 2,
    parameter int CNT_WIDTH    = 8,
    parameter int LEAK_SHIFT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    lif_neuron_array_if.slave  bus
);
    localparam int N  = NUM_NEURONS;
    localparam int W  = WEIGHT_WIDTH;
    localparam int P  = POT_WIDTH;
    localparam int C  = CNT_WIDTH;
    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACTORY);
    localparam logic signed [P:0] V_MAX = {2'b00, {(P-1){1'b1}}};
    localparam logic signed [P:0] V_MIN = {2'b11, {(P-1){1'b0}}};

    // Reject configurations the datapath cannot represent.
    if (P <= W || LEAK_SHIFT < 0 || LEAK_SHIFT >= P) begin : g_bad_cfg
        $error("lif_neuron_array: bad POT_WIDTH/WEIGHT_WIDTH/LEAK_SHIFT");
    end

    logic signed [P-1:0] v_q    [N];
    logic signed [P-1:0] v_d    [N];
    logic [RW-1:0]       refr_q [N];
    logic [RW-1:0]       refr_d [N];
    logic [C-1:0]        cnt_q  [N];
    logic [C-1:0]        cnt_d  [N];
    logic [N-1:0]        spike_q;
    logic [N-1:0]        spike_d;

    logic signed [P:0]   w_ext  [N];
    logic signed [P:0]   v_ext  [N];
    logic signed [P:0]   v_base [N];
    logic signed [P:0]   sum    [N];
    logic signed [P-1:0] vn     [N];
    logic [N-1:0]        fire;

    // Candidate potential per neuron: optional leak, add weight, clamp.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_ext[i] = {{(P+1-W){bus.data_in[i*W+W-1]}},
                        bus.data_in[i*W +: W]};
            v_ext[i] = {v_q[i][P-1], v_q[i]};
`ifdef LIF_LEAK_EN
            v_base[i] = v_ext[i] - (v_ext[i] >>> LEAK_SHIFT);
`else
            v_base[i] = v_ext[i];
`endif
            sum[i] = v_base[i] + w_ext[i];
            if (sum[i] > V_MAX) begin
                vn[i] = V_MAX[P-1:0];
            end else if (sum[i] < V_MIN) begin
                vn[i] = V_MIN[P-1:0];
            end else begin
                vn[i] = sum[i][P-1:0];
            end
            fire[i] = (vn[i] >= bus.threshold);
        end
    end

    // Next state: clear beats step; refractory neurons only count down.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            v_d[i]     = v_q[i];
            refr_d[i]  = refr_q[i];
            cnt_d[i]   = cnt_q[i];
            spike_d[i] = 1'b0;
            if (bus.clr) begin
                v_d[i]    = '0;
                refr_d[i] = '0;
                cnt_d[i]  = '0;
            end else if (bus.clken) begin
                if (refr_q[i] != '0) begin
                    refr_d[i] = refr_q[i] - 1'b1;
                end else if (fire[i]) begin
                    v_d[i]     = '0;
                    refr_d[i]  = REFR_LOAD;
                    spike_d[i] = 1'b1;
                    if (cnt_q[i] != {C{1'b1}}) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    v_d[i] = vn[i];
                end
            end
        end
    end

    // Neuron state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            spike_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            spike_q <= spike_d;
        end
    end

    assign bus.spike_out = spike_q;

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign bus.spike_cnt[g*C +: C] = cnt_q[g];
    end
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (4 neurons, W=8,
// P=16, REFRACTORY=2); leak expectations follow LIF_LEAK_EN.
module tb_lif_neuron_array;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lif_neuron_array_if #(
        .NUM_NEURONS(4), .WEIGHT_WIDTH(8),
        .POT_WIDTH(16), .CNT_WIDTH(8)
    ) bus ();

    lif_neuron_array #(
        .NUM_NEURONS(4), .WEIGHT_WIDTH(8), .POT_WIDTH(16),
        .REFRACTORY(2), .CNT_WIDTH(8), .LEAK_SHIFT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // One clken step with the given packed weights {w3,w2,w1,w0}.
    task automatic step(input logic [31:0] w);
        bus.data_in = w;
        bus.clken   = 1'b1;
        @(negedge clk);
        bus.clken   = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic clear_all();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clken = 1'b0;
        bus.clr = 1'b0;
        bus.data_in = '0;
        bus.threshold = 16'sd100;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.spike_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_spike got %b exp 0000", bus.spike_out);
        end
        checks++;
        if (bus.spike_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h exp 0", bus.spike_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.v_q[i] !== 16'sd0) begin
                errors++;
                $display("FAIL reset_v%0d got %0d exp 0", i, dut.v_q[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_integrate_fire();
        logic signed [15:0] exp_v;
        bus.threshold = 16'sd100;
        for (int s = 1; s <= 3; s++) begin
            step(32'h0000_001E);
            exp_v = 16'(30 * s);
            checks++;
            if (dut.v_q[0] !== exp_v || bus.spike_out !== 4'b0000) begin
                errors++;
                $display("FAIL integ_step%0d v=%0d spk=%b exp v=%0d spk=0000",
                         s, dut.v_q[0], bus.spike_out, exp_v);
            end
        end
        step(32'h0000_001E);
        checks++;
        if (bus.spike_out !== 4'b0001 || dut.v_q[0] !== 16'sd0) begin
            errors++;
            $display("FAIL integ_fire spk=%b v=%0d exp spk=0001 v=0",
                     bus.spike_out, dut.v_q[0]);
        end
        checks++;
        if (bus.spike_cnt !== 32'h0000_0001) begin
            errors++;
            $display("FAIL integ_cnt got %h exp 00000001", bus.spike_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.spike_out !== 4'b0000) begin
            errors++;
            $display("FAIL integ_pulse_len got %b exp 0000", bus.spike_out);
        end
    endtask

    task automatic test_refractory();
        // Idle clocks do not consume the refractory window.
        repeat (3) @(negedge clk);
        step(32'h0000_007F);
        checks++;
        if (dut.v_q[0] !== 16'sd0 || bus.spike_out !== 4'b0000) begin
            errors++;
            $display("FAIL refr_step1 v=%0d spk=%b exp v=0 spk=0000",
                     dut.v_q[0], bus.spike_out);
        end
        @(negedge clk);
        step(32'h0000_007F);
        checks++;
        if (dut.v_q[0] !== 16'sd0 || bus.spike_out !== 4'b0000) begin
            errors++;
            $display("FAIL refr_step2 v=%0d spk=%b exp v=0 spk=0000",
                     dut.v_q[0], bus.spike_out);
        end
        step(32'h0000_007F);
        checks++;
        if (bus.spike_out !== 4'b0001 || bus.spike_cnt !== 32'h0000_0002) begin
            errors++;
            $display("FAIL refr_step3 spk=%b cnt=%h exp spk=0001 cnt=00000002",
                     bus.spike_out, bus.spike_cnt);
        end
    endtask

    task automatic test_saturation();
        int spikes;
        clear_all();
        bus.threshold = 16'sd32767;
        spikes = 0;
        for (int s = 0; s < 258; s++) begin
            step(32'h0000_7F00);
            if (bus.spike_out !== 4'b0000) spikes++;
        end
        checks++;
        if (spikes != 0 || dut.v_q[1] !== 16'sd32766) begin
            errors++;
            $display("FAIL sat_pos_258 spikes=%0d v=%0d exp 0 and 32766",
                     spikes, dut.v_q[1]);
        end
        step(32'h0000_7F00);
        checks++;
        if (bus.spike_out !== 4'b0010 || dut.v_q[1] !== 16'sd0) begin
            errors++;
            $display("FAIL sat_pos_fire spk=%b v=%0d exp spk=0010 v=0",
                     bus.spike_out, dut.v_q[1]);
        end
        clear_all();
        spikes = 0;
        for (int s = 0; s < 300; s++) begin
            step(32'h0000_8000);
            if (bus.spike_out !== 4'b0000) spikes++;
        end
        checks++;
        if (spikes != 0 || dut.v_q[1] !== -16'sd32768) begin
            errors++;
            $display("FAIL sat_neg spikes=%0d v=%0d exp 0 and -32768",
                     spikes, dut.v_q[1]);
        end
    endtask

    task automatic test_clear();
        clear_all();
        bus.threshold = 16'sd100;
        step(32'h0000_0064);
        step(32'h005A_0000);
        checks++;
        if (dut.v_q[2] !== 16'sd90 || bus.spike_cnt !== 32'h0000_0001) begin
            errors++;
            $display("FAIL clr_setup v2=%0d cnt=%h exp 90 00000001",
                     dut.v_q[2], bus.spike_cnt);
        end
        bus.clr = 1'b1;
        step(32'h0032_0000);
        bus.clr = 1'b0;
        checks++;
        if (dut.v_q[2] !== 16'sd0 || bus.spike_out !== 4'b0000 ||
            bus.spike_cnt !== 32'h0) begin
            errors++;
            $display("FAIL clr_beats_clken v2=%0d spk=%b cnt=%h exp 0 0000 0",
                     dut.v_q[2], bus.spike_out, bus.spike_cnt);
        end
    endtask

    task automatic test_async_reset();
        clear_all();
        bus.threshold = 16'sd100;
        step(32'h6464_6464);
        bus.data_in = 32'h3C3C_3C3C;
        bus.clken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.spike_out !== 4'b0000 || bus.spike_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_rst spk=%b cnt=%h exp 0000 0",
                     bus.spike_out, bus.spike_cnt);
        end
        @(negedge clk);
        bus.clken = 1'b0;
        bus.data_in = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_spk [4];
        exp_spk[0] = 4'b1111;
        exp_spk[1] = 4'b0000;
        exp_spk[2] = 4'b0000;
        exp_spk[3] = 4'b1111;
        clear_all();
        bus.threshold = 16'sd100;
        bus.data_in = 32'h6464_6464;
        bus.clken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.spike_out !== exp_spk[c]) begin
                errors++;
                $display("FAIL b2b_cycle%0d got %b exp %b",
                         c, bus.spike_out, exp_spk[c]);
            end
        end
        bus.clken = 1'b0;
        bus.data_in = '0;
        checks++;
        if (bus.spike_cnt !== 32'h0202_0202) begin
            errors++;
            $display("FAIL b2b_cnt got %h exp 02020202", bus.spike_cnt);
        end
    endtask

    task automatic test_leak();
        logic signed [15:0] exp_v [3];
`ifdef LIF_LEAK_EN
        exp_v[0] = 16'sd60;
        exp_v[1] = 16'sd45;
        exp_v[2] = 16'sd34;
`else
        exp_v[0] = 16'sd80;
        exp_v[1] = 16'sd80;
        exp_v[2] = 16'sd80;
`endif
        clear_all();
        bus.threshold = 16'sd100;
        step(32'h5000_0000);
        checks++;
        if (dut.v_q[3] !== 16'sd80) begin
            errors++;
            $display("FAIL leak_load v3=%0d exp 80", dut.v_q[3]);
        end
        for (int s = 0; s < 3; s++) begin
            step(32'h0);
            checks++;
            if (dut.v_q[3] !== exp_v[s]) begin
                errors++;
                $display("FAIL leak_step%0d v3=%0d exp %0d",
                         s, dut.v_q[3], exp_v[s]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dut.v_q[3] !== exp_v[2] || bus.spike_out !== 4'b0000) begin
            errors++;
            $display("FAIL idle_hold v3=%0d spk=%b exp %0d 0000",
                     dut.v_q[3], bus.spike_out, exp_v[2]);
        end
    endtask

    task automatic test_threshold_nonpos();
        clear_all();
        bus.threshold = 16'sd0;
        step(32'h0);
        checks++;
        if (bus.spike_out !== 4'b1111) begin
            errors++;
            $display("FAIL thr_zero got %b exp 1111", bus.spike_out);
        end
        clear_all();
        bus.threshold = -16'sd5;
        step(32'h0000_00F6);
        checks++;
        if (bus.spike_out !== 4'b1110 || dut.v_q[0] !== -16'sd10) begin
            errors++;
            $display("FAIL thr_neg_below spk=%b v0=%0d exp 1110 -10",
                     bus.spike_out, dut.v_q[0]);
        end
        repeat (2) step(32'h0);
        step(32'h0000_0006);
        checks++;
        if (bus.spike_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL thr_neg_cross spk0=%b exp 1", bus.spike_out[0]);
        end
    endtask

    task automatic test_cnt_saturate();
        clear_all();
        bus.threshold = 16'sd0;
        bus.data_in = 32'h0;
        bus.clken = 1'b1;
        repeat (3 * 260) @(negedge clk);
        bus.clken = 1'b0;
        checks++;
        if (bus.spike_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cnt_sat got %h exp ffffffff", bus.spike_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.clken = 1'b0;
        bus.clr = 1'b0;
        bus.data_in = '0;
        bus.threshold = 16'sd100;
        @(negedge clk);
        test_reset();
        test_integrate_fire();
        test_refractory();
        test_saturation();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_leak();
        test_threshold_nonpos();
        test_cnt_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
